// File: rtl/encoder_pkg.sv
// Shared types and helpers for the quadrature encoder velocity front end.
//   quad_state_t : synchronized pin pair {A,B}
//   quad_delta_t : per-cycle decoded movement
//   sat_add16    : saturating +/-1 step of a signed 16-bit accumulator
package encoder_pkg;

    localparam int unsigned VEL_W = 16;

    typedef logic [1:0] quad_state_t;

    typedef enum logic [1:0] {
        DELTA_ZERO    = 2'd0,
        DELTA_PLUS    = 2'd1,
        DELTA_MINUS   = 2'd2,
        DELTA_ILLEGAL = 2'd3
    } quad_delta_t;

    localparam logic signed [VEL_W-1:0] VEL_MAX = 16'sh7FFF;
    localparam logic signed [VEL_W-1:0] VEL_MIN = 16'sh8000;

    // Apply one decoded step to acc, clamping at the signed 16-bit limits.
    function automatic logic signed [VEL_W-1:0] sat_add16(
        input logic signed [VEL_W-1:0] acc,
        input quad_delta_t             d
    );
        logic signed [VEL_W-1:0] r;
        r = acc;
        case (d)
            DELTA_PLUS:  if (acc != VEL_MAX) r = acc + 16'sd1;
            DELTA_MINUS: if (acc != VEL_MIN) r = acc - 16'sd1;
            default:     r = acc;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/quadrature_decoder.sv
// Synchronizes the raw encoder pins and decodes x4 quadrature movement.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   enc_a, enc_b : asynchronous encoder pins
//   delta_c      : combinational decode of (synchronized state vs previous)
module quadrature_decoder
    import encoder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enc_a,
    input  logic        enc_b,
    output quad_delta_t delta_c
);

    quad_state_t sync1;
    quad_state_t sync2;
    quad_state_t prev;
    logic [1:0]  cur_phase;
    logic [1:0]  prev_phase;
    logic [1:0]  phase_step;

    // Two-flop synchronizer followed by the previous-state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= {enc_a, enc_b};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Gray-to-binary turns the forward cycle 00,01,11,10 into 0,1,2,3,
    // so the modulo-4 difference directly gives direction (1/3) or a skip (2).
    always_comb begin
        cur_phase  = {sync2[1], sync2[1] ^ sync2[0]};
        prev_phase = {prev[1], prev[1] ^ prev[0]};
        phase_step = cur_phase - prev_phase;
        delta_c    = DELTA_ZERO;
        case (phase_step)
            2'd1:    delta_c = DELTA_PLUS;
            2'd2:    delta_c = DELTA_ILLEGAL;
            2'd3:    delta_c = DELTA_MINUS;
            default: delta_c = DELTA_ZERO;
        endcase
    end

endmodule

// File: rtl/encoder_velocity_estimator.sv
// Quadrature encoder front end: position count, illegal-transition flag and
// a windowed signed velocity sample with a one-cycle valid strobe.
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   enable              : run the velocity window (held cleared when low)
//   enc_a, enc_b        : asynchronous encoder pins
//   clear_error         : clears quad_error (an illegal step in the same cycle wins)
//   raw_signed_velocity : saturated edge count of the last completed window
//   sample_valid        : one-cycle pulse when raw_signed_velocity updates
//   position            : signed free-running edge count, wraps at POS_W
//   quad_error          : sticky illegal-transition flag
module encoder_velocity_estimator
    import encoder_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 50000,
    parameter int unsigned POS_W         = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    enc_a,
    input  logic                    enc_b,
    input  logic                    clear_error,
    output logic signed [VEL_W-1:0] raw_signed_velocity,
    output logic                    sample_valid,
    output logic signed [POS_W-1:0] position,
    output logic                    quad_error
);

    localparam int unsigned CNT_W = $clog2(WINDOW_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_CYCLES - 1);

    quad_delta_t             delta_c;
    logic [CNT_W-1:0]        win_cnt;
    logic signed [VEL_W-1:0] acc;
    logic                    terminal_c;

    quadrature_decoder u_decoder (
        .clk     (clk),
        .reset   (reset),
        .enc_a   (enc_a),
        .enc_b   (enc_b),
        .delta_c (delta_c)
    );

    assign terminal_c = enable && (win_cnt == CNT_LAST);

    // Position and error flag track the pins independently of enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            position   <= '0;
            quad_error <= 1'b0;
        end else begin
            case (delta_c)
                DELTA_PLUS:  position <= position + POS_W'(1);
                DELTA_MINUS: position <= position - POS_W'(1);
                default:     position <= position;
            endcase
            if (delta_c == DELTA_ILLEGAL) begin
                quad_error <= 1'b1;
            end else if (clear_error) begin
                quad_error <= 1'b0;
            end
        end
    end

    // Velocity window: the terminal cycle's own step closes into the sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt             <= '0;
            acc                 <= '0;
            raw_signed_velocity <= '0;
            sample_valid        <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (!enable) begin
                win_cnt <= '0;
                acc     <= '0;
            end else if (terminal_c) begin
                raw_signed_velocity <= sat_add16(acc, delta_c);
                sample_valid        <= 1'b1;
                acc                 <= '0;
                win_cnt             <= '0;
            end else begin
                acc     <= sat_add16(acc, delta_c);
                win_cnt <= win_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_encoder_velocity_estimator.sv
// Bench for encoder_velocity_estimator: a short-window instance (8) and a
// long-window instance (40000) share the pins; a behavioural model based on
// pin history tracks both.
module tb_encoder_velocity_estimator;

    localparam int WIN_S = 8;
    localparam int WIN_B = 40000;

    logic clk;
    logic reset;
    logic enable_s;
    logic enable_b;
    logic enc_a;
    logic enc_b;
    logic clear_error;

    logic signed [15:0] raw_s, raw_b;
    logic               valid_s, valid_b;
    logic signed [31:0] pos_s, pos_b;
    logic               err_s, err_b;

    int checks = 0;
    int errors = 0;

    // Forward quadrature order; a step is a move of one slot in this table.
    logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int gidx = 0;

    encoder_velocity_estimator #(.WINDOW_CYCLES(WIN_S), .POS_W(32)) dut_s (
        .clk(clk), .reset(reset), .enable(enable_s), .enc_a(enc_a), .enc_b(enc_b),
        .clear_error(clear_error), .raw_signed_velocity(raw_s), .sample_valid(valid_s),
        .position(pos_s), .quad_error(err_s)
    );

    encoder_velocity_estimator #(.WINDOW_CYCLES(WIN_B), .POS_W(32)) dut_b (
        .clk(clk), .reset(reset), .enable(enable_b), .enc_a(enc_a), .enc_b(enc_b),
        .clear_error(clear_error), .raw_signed_velocity(raw_b), .sample_valid(valid_b),
        .position(pos_b), .quad_error(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Pins become visible to the decoder two samples later; movement is judged
    // between the samples taken two and three edges before the current edge.
    logic [1:0]         h1, h2, h3;
    logic signed [31:0] m_pos [2];
    bit                 m_err [2];
    int                 m_cnt [2];
    int                 m_acc [2];
    int                 m_raw [2];
    bit                 m_valid [2];
    int                 md;
    bit                 mill;
    int                 mdiff;
    int                 mwin;
    bit                 men;

    function automatic int pos_of(input logic [1:0] s);
        for (int i = 0; i < 4; i++) if (seq[i] == s) return i;
        return 0;
    endfunction

    function automatic int clamp16(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            h1 = 2'b00; h2 = 2'b00; h3 = 2'b00;
            for (int k = 0; k < 2; k++) begin
                m_pos[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
                m_acc[k] = 0; m_raw[k] = 0; m_valid[k] = 0;
            end
        end else begin
            mdiff = (pos_of(h2) - pos_of(h3) + 4) % 4;
            md    = (mdiff == 1) ? 1 : ((mdiff == 3) ? -1 : 0);
            mill  = (mdiff == 2);
            for (int k = 0; k < 2; k++) begin
                mwin = (k == 0) ? WIN_S : WIN_B;
                men  = (k == 0) ? enable_s : enable_b;
                m_pos[k] = m_pos[k] + 32'(md);
                if (mill) m_err[k] = 1;
                else if (clear_error) m_err[k] = 0;
                m_valid[k] = 0;
                if (!men) begin
                    m_cnt[k] = 0; m_acc[k] = 0;
                end else if (m_cnt[k] == mwin - 1) begin
                    m_raw[k] = clamp16(m_acc[k] + md);
                    m_valid[k] = 1; m_acc[k] = 0; m_cnt[k] = 0;
                end else begin
                    m_acc[k] = clamp16(m_acc[k] + md);
                    m_cnt[k] = m_cnt[k] + 1;
                end
            end
            h3 = h2; h2 = h1; h1 = {enc_a, enc_b};
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_pins();
        {enc_a, enc_b} = seq[gidx];
    endtask

    task automatic step_fwd();
        gidx = (gidx + 1) % 4;
        drive_pins();
    endtask

    task automatic step_rev();
        gidx = (gidx + 3) % 4;
        drive_pins();
    endtask

    task automatic jump_illegal();
        gidx = (gidx + 2) % 4;
        drive_pins();
    endtask

    // Restart the short window so its first edge is the next clock.
    task automatic align_s();
        enable_s = 1'b0;
        tick(2);
        enable_s = 1'b1;
    endtask

    // Cycles until valid_s, counting from 'start'; -1 if the bound expires.
    task automatic wait_pulse(input int start, output int k);
        k = start;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            k++;
            if (valid_s) return;
        end
        k = -1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks++; if (raw_s !== 16'sd0) begin errors++; $display("FAIL reset_raw got %0d want 0", raw_s); end
        checks++; if (valid_s !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_s); end
        checks++; if (pos_s !== 32'sd0) begin errors++; $display("FAIL reset_pos got %0d want 0", pos_s); end
        checks++; if (err_s !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_s); end
        checks++; if (pos_b !== 32'sd0) begin errors++; $display("FAIL reset_pos_b got %0d want 0", pos_b); end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_forward();
        int k;
        align_s();
        step_fwd(); tick(1);
        step_fwd(); tick(1);
        step_fwd();
        wait_pulse(2, k);
        checks++; if (k !== 8) begin errors++; $display("FAIL fwd_pulse_spacing got %0d want 8", k); end
        checks++; if (raw_s !== 16'sd3) begin errors++; $display("FAIL fwd_raw got %0d want 3", raw_s); end
        checks++; if (pos_s !== 32'sd3) begin errors++; $display("FAIL fwd_pos got %0d want 3", pos_s); end
    endtask

    task automatic test_reverse();
        int k;
        step_rev();
        repeat (4) begin tick(1); step_rev(); end
        wait_pulse(4, k);
        checks++; if (k !== 8) begin errors++; $display("FAIL rev_pulse_spacing got %0d want 8", k); end
        checks++; if (raw_s !== 16'shFFFB) begin errors++; $display("FAIL rev_raw got %h want fffb", raw_s); end
        checks++; if (pos_s !== -32'sd2) begin errors++; $display("FAIL rev_pos got %0d want -2", pos_s); end
        wait_pulse(0, k);
        checks++; if (k !== 8) begin errors++; $display("FAIL idle_pulse_spacing got %0d want 8", k); end
        checks++; if (raw_s !== 16'sd0) begin errors++; $display("FAIL idle_raw got %0d want 0", raw_s); end
        tick(1);
        checks++; if (valid_s !== 1'b0) begin errors++; $display("FAIL valid_one_cycle got %b want 0", valid_s); end
    endtask

    task automatic test_illegal();
        jump_illegal();
        tick(2);
        checks++; if (err_s !== 1'b0) begin errors++; $display("FAIL illegal_early got %b want 0", err_s); end
        tick(1);
        checks++; if (err_s !== 1'b1) begin errors++; $display("FAIL illegal_set got %b want 1", err_s); end
        checks++; if (pos_s !== -32'sd2) begin errors++; $display("FAIL illegal_pos got %0d want -2", pos_s); end
        clear_error = 1'b1; tick(1); clear_error = 1'b0;
        checks++; if (err_s !== 1'b0) begin errors++; $display("FAIL illegal_clear got %b want 0", err_s); end
        jump_illegal();
        tick(2);
        clear_error = 1'b1; tick(1); clear_error = 1'b0;
        checks++; if (err_s !== 1'b1) begin errors++; $display("FAIL set_wins got %b want 1", err_s); end
        clear_error = 1'b1; tick(1); clear_error = 1'b0;
        checks++; if (err_s !== 1'b0) begin errors++; $display("FAIL reclear got %b want 0", err_s); end
    endtask

    task automatic test_terminal();
        int k;
        align_s();
        step_fwd();
        tick(5); step_fwd();   // lands in the terminal cycle
        tick(1); step_fwd();   // lands in the next window
        wait_pulse(6, k);
        checks++; if (k !== 8) begin errors++; $display("FAIL term_pulse_spacing got %0d want 8", k); end
        checks++; if (raw_s !== 16'sd2) begin errors++; $display("FAIL term_raw got %0d want 2", raw_s); end
        wait_pulse(0, k);
        checks++; if (k !== 8) begin errors++; $display("FAIL term_next_spacing got %0d want 8", k); end
        checks++; if (raw_s !== 16'sd1) begin errors++; $display("FAIL term_next_raw got %0d want 1", raw_s); end
        checks++; if (pos_s !== 32'sd1) begin errors++; $display("FAIL term_pos got %0d want 1", pos_s); end
    endtask

    task automatic test_enable_drop();
        int k;
        bit seen;
        align_s();
        step_fwd(); tick(1);
        step_fwd(); tick(3);
        enable_s = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 3) step_fwd();
            tick(1);
            if (valid_s) seen = 1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL drop_no_pulse got %b want 0", seen); end
        checks++; if (raw_s !== 16'sd1) begin errors++; $display("FAIL drop_raw_hold got %0d want 1", raw_s); end
        checks++; if (pos_s !== 32'sd6) begin errors++; $display("FAIL drop_pos got %0d want 6", pos_s); end
        enable_s = 1'b1;
        wait_pulse(0, k);
        checks++; if (k !== 8) begin errors++; $display("FAIL reenable_spacing got %0d want 8", k); end
        checks++; if (raw_s !== 16'sd0) begin errors++; $display("FAIL reenable_raw got %0d want 0", raw_s); end
    endtask

    task automatic test_reset_mid();
        int k;
        // Park the pins so the two steps below end at 00, matching the reset state.
        while (gidx != 2) begin step_fwd(); tick(1); end
        tick(4);
        align_s();
        step_fwd(); tick(1);
        step_fwd(); tick(4);
        reset = 1'b1; tick(1); reset = 1'b0;
        checks++; if (raw_s !== 16'sd0) begin errors++; $display("FAIL rstmid_raw got %0d want 0", raw_s); end
        checks++; if (valid_s !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", valid_s); end
        checks++; if (pos_s !== 32'sd0) begin errors++; $display("FAIL rstmid_pos got %0d want 0", pos_s); end
        checks++; if (err_s !== 1'b0) begin errors++; $display("FAIL rstmid_err got %b want 0", err_s); end
        wait_pulse(0, k);
        checks++; if (k !== 8) begin errors++; $display("FAIL rstmid_spacing got %0d want 8", k); end
        checks++; if (raw_s !== 16'sd0) begin errors++; $display("FAIL rstmid_raw_after got %0d want 0", raw_s); end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 19);
            if (r < 6) step_fwd();
            else if (r < 10) step_rev();
            else if (r == 19 && $urandom_range(0, 3) == 0) jump_illegal();
            if ($urandom_range(0, 39) == 0) enable_s = ~enable_s;
            clear_error = ($urandom_range(0, 15) == 0);
            tick(1);
            checks++; if (raw_s !== 16'(m_raw[0])) begin errors++; $display("FAIL rnd_raw cyc %0d got %0d want %0d", i, raw_s, m_raw[0]); end
            checks++; if (valid_s !== m_valid[0]) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", i, valid_s, m_valid[0]); end
            checks++; if (pos_s !== m_pos[0]) begin errors++; $display("FAIL rnd_pos cyc %0d got %0d want %0d", i, pos_s, m_pos[0]); end
            checks++; if (err_s !== m_err[0]) begin errors++; $display("FAIL rnd_err cyc %0d got %b want %b", i, err_s, m_err[0]); end
            checks++; if (pos_b !== m_pos[1]) begin errors++; $display("FAIL rnd_pos_b cyc %0d got %0d want %0d", i, pos_b, m_pos[1]); end
        end
        clear_error = 1'b0;
        enable_s = 1'b1;
    endtask

    task automatic test_saturation();
        int kb;
        enable_b = 1'b0;
        tick(2);
        enable_b = 1'b1;
        kb = -1;
        for (int i = 1; i <= WIN_B + 10; i++) begin
            step_fwd();
            tick(1);
            if (valid_b) begin kb = i; break; end
        end
        checks++; if (kb !== WIN_B) begin errors++; $display("FAIL sat_spacing got %0d want %0d", kb, WIN_B); end
        checks++; if (raw_b !== 16'sh7FFF) begin errors++; $display("FAIL sat_raw got %0d want 32767", raw_b); end
        checks++; if (raw_b !== 16'(m_raw[1])) begin errors++; $display("FAIL sat_model got %0d want %0d", raw_b, m_raw[1]); end
        checks++; if (pos_s !== m_pos[0]) begin errors++; $display("FAIL sat_pos_s got %0d want %0d", pos_s, m_pos[0]); end
    endtask

    initial begin
        reset = 1'b1;
        enable_s = 1'b0;
        enable_b = 1'b0;
        clear_error = 1'b0;
        gidx = 0;
        drive_pins();
        test_reset();
        test_forward();
        test_reverse();
        test_illegal();
        test_terminal();
        test_enable_drop();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
